// File: rtl/ex_if.sv
// rtl/ex_if.sv - EX-to-data-SRAM request and MEM load/store descriptor signals
interface ex_if;
  logic [4:0]  load_sram_ex_data;
  logic [2:0]  store_sram_ex_data;
  logic [3:0]  data_ram_sel;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (
    output load_sram_ex_data,
    output store_sram_ex_data,
    output data_ram_sel,
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata
  );

  modport slave (
    input load_sram_ex_data,
    input store_sram_ex_data,
    input data_ram_sel,
    input data_sram_en,
    input data_sram_wen,
    input data_sram_addr,
    input data_sram_wdata
  );
endinterface

// File: rtl/ex.sv
// rtl/ex.sv - execute stage: ID/EX register, ALU, load/store request, iterative divider with HI/LO
module ex (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [149:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [38:0]  ex_to_id_bus,
  ex_if.master         mem_if,
  output logic         stallreq_for_ex
);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  logic [149:0] id_ex_q, id_ex_d;

  always_comb begin
    id_ex_d = id_ex_q;
    if (stall[2] == STOP && stall[3] == NO_STOP) begin
      id_ex_d = '0;
    end else if (stall[2] == NO_STOP) begin
      id_ex_d = id_to_ex_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  logic [31:0] pc;
  logic [4:0]  alu_op;
  logic [31:0] rs_val, rt_val, imm;
  logic        use_imm, rf_we;
  logic [4:0]  rf_waddr;
  logic [4:0]  load_op;
  logic [2:0]  store_op;
  logic [1:0]  div_op;

  assign pc       = id_ex_q[149:118];
  assign alu_op   = id_ex_q[117:113];
  assign rs_val   = id_ex_q[112:81];
  assign rt_val   = id_ex_q[80:49];
  assign imm      = id_ex_q[48:17];
  assign use_imm  = id_ex_q[16];
  assign rf_we    = id_ex_q[15];
  assign rf_waddr = id_ex_q[14:10];
  assign load_op  = id_ex_q[9:5];
  assign store_op = id_ex_q[4:2];
  assign div_op   = id_ex_q[1:0];

  logic [31:0] op_a, op_b;
  assign op_a = rs_val;
  assign op_b = use_imm ? imm : rt_val;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] alu_res;

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      5'd0:  alu_res = op_a + op_b;
      5'd1:  alu_res = op_a - op_b;
      5'd2:  alu_res = op_a & op_b;
      5'd3:  alu_res = op_a | op_b;
      5'd4:  alu_res = op_a ^ op_b;
      5'd5:  alu_res = ~(op_a | op_b);
      5'd6:  alu_res = op_b << op_a[4:0];
      5'd7:  alu_res = op_b >> op_a[4:0];
      5'd8:  alu_res = $unsigned($signed(op_b) >>> op_a[4:0]);
      5'd9:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      5'd10: alu_res = {31'd0, op_a < op_b};
      5'd11: alu_res = op_b;
      5'd12: alu_res = hi_q;
      5'd13: alu_res = lo_q;
      default: alu_res = 32'd0;
    endcase
  end

  logic        is_load, is_store, is_mem, is_div;
  logic [31:0] mem_addr;
  logic [3:0]  store_wen, load_sel;
  logic [31:0] store_wdata;

  assign is_load  = |load_op;
  assign is_store = |store_op;
  assign is_mem   = is_load | is_store;
  assign is_div   = |div_op;
  assign mem_addr = rs_val + imm;

  // Stores replicate the datum across every lane so the byte enables alone pick the target.
  always_comb begin
    store_wen   = 4'b0000;
    store_wdata = 32'd0;
    if (store_op[2]) begin
      store_wen   = 4'b0001 << mem_addr[1:0];
      store_wdata = {4{rt_val[7:0]}};
    end else if (store_op[1]) begin
      store_wen   = mem_addr[1] ? 4'b1100 : 4'b0011;
      store_wdata = {2{rt_val[15:0]}};
    end else if (store_op[0]) begin
      store_wen   = 4'b1111;
      store_wdata = rt_val;
    end
  end

  always_comb begin
    load_sel = 4'b0000;
    if (load_op[4] | load_op[3]) begin
      load_sel = 4'b0001 << mem_addr[1:0];
    end else if (load_op[2] | load_op[1]) begin
      load_sel = mem_addr[1] ? 4'b1100 : 4'b0011;
    end else if (load_op[0]) begin
      load_sel = 4'b1111;
    end
  end

  // Lane select follows the instruction into MEM, where the read data comes back.
  logic [3:0] data_ram_sel_q, data_ram_sel_d;

  always_comb begin
    data_ram_sel_d = data_ram_sel_q;
    if (stall[3] == STOP && stall[4] == NO_STOP) begin
      data_ram_sel_d = 4'b0000;
    end else if (stall[3] == NO_STOP) begin
      data_ram_sel_d = load_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_ram_sel_q <= 4'b0000;
    else     data_ram_sel_q <= data_ram_sel_d;
  end

  div_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, div_zero_q, div_zero_d;
  logic        div_signed;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;

  assign div_signed = div_op[1];
  assign rem_sh     = {rem_q, quo_q[31]};
  assign rem_sub    = rem_sh[31:0] - dvs_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    dvd_d      = dvd_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      DIV_IDLE: begin
        if (is_div) begin
          state_d    = DIV_BUSY;
          cnt_d      = 5'd0;
          rem_d      = 32'd0;
          quo_d      = (div_signed && op_a[31]) ? 32'd0 - op_a : op_a;
          dvs_d      = (div_signed && op_b[31]) ? 32'd0 - op_b : op_b;
          dvd_d      = op_a;
          neg_quo_d  = div_signed & (op_a[31] ^ op_b[31]);
          neg_rem_d  = div_signed & op_a[31];
          div_zero_d = (op_b == 32'd0);
        end
      end
      DIV_BUSY: begin
        // Restoring step: shift in the next dividend bit, subtract if it fits.
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = rem_sub;
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (stall[2] == NO_STOP) begin
          if (div_zero_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = dvd_q;
          end else begin
            lo_d = neg_quo_q ? 32'd0 - quo_q : quo_q;
            hi_d = neg_rem_q ? 32'd0 - rem_q : rem_q;
          end
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= 5'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
      dvd_q      <= 32'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      dvd_q      <= dvd_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign stallreq_for_ex = (state_q == DIV_IDLE && is_div) || (state_q == DIV_BUSY);

  logic        rf_we_out;
  logic [31:0] ex_result;

  assign rf_we_out = rf_we & ~is_div;
  assign ex_result = is_mem ? mem_addr : alu_res;

  assign ex_to_mem_bus = {pc, is_mem, store_wen, is_load, rf_we_out, rf_waddr, ex_result};
  assign ex_to_id_bus  = {is_load, rf_we_out, rf_waddr, ex_result};

  assign mem_if.load_sram_ex_data  = load_op;
  assign mem_if.store_sram_ex_data = store_op;
  assign mem_if.data_ram_sel       = data_ram_sel_q;
  assign mem_if.data_sram_en       = is_mem;
  assign mem_if.data_sram_wen      = store_wen;
  assign mem_if.data_sram_addr     = mem_addr;
  assign mem_if.data_sram_wdata    = store_wdata;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[1:0]};

endmodule
